// File: rtl/handshake_tx.sv
// Transmit side of a four-phase req/ack handshake: accepts a word over valid/ready,
// holds it on data_out and runs req/ack through an internal ack synchronizer.
// Optional per-phase timeout is enabled by defining HANDSHAKE_TX_TIMEOUT_EN.
module handshake_tx #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_sync;

`ifdef HANDSHAKE_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             phase_expired;

  assign phase_expired = (cnt_q == CNT_LAST);
`endif

  // ack_in is asynchronous; only the last synchronizer stage is ever observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
    terr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = REQ_HI;
      end
      REQ_HI: begin
        if (ack_sync) begin
          state_d = REQ_LO;
        end
`ifdef HANDSHAKE_TX_TIMEOUT_EN
        else if (phase_expired) begin
          state_d = REQ_LO;
          terr_d  = 1'b1;
        end
`endif
      end
      REQ_LO: begin
        if (!ack_sync) begin
          state_d = IDLE;
        end
`ifdef HANDSHAKE_TX_TIMEOUT_EN
        else if (phase_expired) begin
          state_d = IDLE;
          terr_d  = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // req rises on entry to REQ_HI and falls on leaving it, one flop after the decision.
    req_d = (state_d == REQ_HI);

`ifdef HANDSHAKE_TX_TIMEOUT_EN
    if (state_d != state_q || (state_q != REQ_HI && state_q != REQ_LO)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  assign req_out  = req_q;
  assign data_out = data_q;

`ifdef HANDSHAKE_TX_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_tx.sv
// Directed bench for handshake_tx: reset, table-driven loopback handshake, back-to-back
// words, reset mid-REQ_HI and the ack-stuck-low case (timeout or indefinite hold).
module tb_handshake_tx;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             req_out;
  logic [WIDTH-1:0] data_out;
  logic             ack_in;
  logic             busy;
  logic             timeout_err;
  logic             loopback;
  logic             ack_force;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             exp_ready;
    logic             exp_req;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  vec_t vecs[16];
  logic [WIDTH-1:0] words[3];

  assign ack_in = loopback ? req_out : ack_force;

  always #5 clk = ~clk;

  handshake_tx #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .req_out(req_out),
    .data_out(data_out),
    .ack_in(ack_in),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data);
    in_valid = valid;
    in_data  = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int hi;
    logic was_ready;
    logic [WIDTH-1:0] exp_word;

    // Per-cycle loopback vectors: inputs before edge Ek, outputs expected after Ek.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5};
    vecs[2]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5};
    vecs[3]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[5]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5};
    vecs[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 8'hA5};
    vecs[8]  = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h77};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h77};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h77};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h77};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h77};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h77};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h77};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h77};
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;

    rst       = 1'b1;
    loopback  = 1'b1;
    ack_force = 1'b0;
    applyStimulus(1'b1, 8'hFF);
    step();
    step();
    checkOutput("reset in_ready", 32'(in_ready), 32'(1));
    checkOutput("reset req_out", 32'(req_out), 32'(0));
    checkOutput("reset data_out", 32'(data_out), 32'(0));
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset timeout_err", 32'(timeout_err), 32'(0));

    applyStimulus(1'b0, 8'h00);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data);
      step();
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d req_out", i), 32'(req_out), 32'(vecs[i].exp_req));
      checkOutput($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(!vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d timeout_err", i), 32'(timeout_err), 32'(0));
    end

    n = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      was_ready = in_ready;
      exp_word  = (n < 3) ? words[n] : 8'h00;
      applyStimulus(1'b1, exp_word);
      step();
      if (was_ready) begin
        checkOutput($sformatf("b2b accept%0d cycle", n), 32'(cyc), 32'(8 * n));
        checkOutput($sformatf("b2b accept%0d data", n), 32'(data_out), 32'(exp_word));
        n++;
      end
      if (req_out) begin
        exp_word = (n >= 1 && n <= 3) ? words[n-1] : 8'h00;
        checkOutput($sformatf("b2b cyc%0d data stable", cyc), 32'(data_out), 32'(exp_word));
      end
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("b2b accept count", 32'(n), 32'(3));
    checkOutput("b2b final in_ready", 32'(in_ready), 32'(1));

    loopback  = 1'b0;
    ack_force = 1'b0;
    applyStimulus(1'b1, 8'hC3);
    step();
    applyStimulus(1'b0, 8'h00);
    step();
    step();
    checkOutput("midrst req before", 32'(req_out), 32'(1));
    checkOutput("midrst data before", 32'(data_out), 32'(8'hC3));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst req_out", 32'(req_out), 32'(0));
    checkOutput("midrst data_out", 32'(data_out), 32'(0));
    checkOutput("midrst in_ready", 32'(in_ready), 32'(1));
    step();
    rst      = 1'b0;
    loopback = 1'b1;
    applyStimulus(1'b1, 8'h96);
    step();
    checkOutput("post-rst accept data", 32'(data_out), 32'(8'h96));
    checkOutput("post-rst accept ready", 32'(in_ready), 32'(0));
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("post-rst req high", 32'(req_out), 32'(1));
    for (int k = 0; k < 6; k++) step();
    checkOutput("post-rst done ready", 32'(in_ready), 32'(1));
    checkOutput("post-rst done req", 32'(req_out), 32'(0));
    checkOutput("post-rst done data", 32'(data_out), 32'(8'h96));

    loopback  = 1'b0;
    ack_force = 1'b0;
    applyStimulus(1'b1, 8'hE1);
    step();
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("stuck req rises", 32'(req_out), 32'(1));
`ifdef HANDSHAKE_TX_TIMEOUT_EN
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!req_out) break;
      hi++;
      checkOutput($sformatf("timeout early pulse k%0d", k), 32'(timeout_err), 32'(0));
    end
    checkOutput("timeout req high cycles", 32'(hi), 32'(16));
    checkOutput("timeout_err pulse", 32'(timeout_err), 32'(1));
    checkOutput("timeout ready during pulse", 32'(in_ready), 32'(0));
    step();
    checkOutput("timeout ready after", 32'(in_ready), 32'(1));
    checkOutput("timeout_err single", 32'(timeout_err), 32'(0));
`else
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (req_out) hi++;
      if (timeout_err) errors++;
    end
    checkOutput("stuck req held cycles", 32'(hi), 32'(40));
    checkOutput("stuck timeout_err", 32'(timeout_err), 32'(0));
    checkOutput("stuck in_ready", 32'(in_ready), 32'(0));
    checkOutput("stuck data_out", 32'(data_out), 32'(8'hE1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
